// File: rtl/axi_cmd_frontend.sv
// ---------------------------------------------------------------------------
// axi_cmd_frontend
// AXI4 slave address/response front-end for the memory controller user port.
// Accepts write bursts on AW and read bursts on AR. Each burst becomes one
// native command per 32-byte beat. One OKAY B response is returned per write
// burst. W and R data are handled by separate blocks.
//
// Ports
//   sys_clk, sys_rst          clock (rising edge), synchronous active-low reset
//   axi_aw_* / axi_ar_*       address channels; only addr/burst/len/id are used
//   axi_b_*                   write response channel (resp always OKAY)
//   native_cmd_*              per-beat command stream; addr is in beat units
// ---------------------------------------------------------------------------
module axi_cmd_frontend #(
   parameter int ADDR_W     = 32,
   parameter int ID_W       = 1,
   parameter int BEAT_SHIFT = 5
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              axi_aw_valid,
   output logic              axi_aw_ready,
   input  logic              axi_aw_first,
   input  logic              axi_aw_last,
   input  logic [ADDR_W-1:0] axi_aw_payload_addr,
   input  logic [1:0]        axi_aw_payload_burst,
   input  logic [7:0]        axi_aw_payload_len,
   input  logic [3:0]        axi_aw_payload_size,
   input  logic [1:0]        axi_aw_payload_lock,
   input  logic [2:0]        axi_aw_payload_prot,
   input  logic [3:0]        axi_aw_payload_cache,
   input  logic [3:0]        axi_aw_payload_qos,
   input  logic [ID_W-1:0]   axi_aw_payload_id,
   input  logic              axi_ar_valid,
   output logic              axi_ar_ready,
   input  logic              axi_ar_first,
   input  logic              axi_ar_last,
   input  logic [ADDR_W-1:0] axi_ar_payload_addr,
   input  logic [1:0]        axi_ar_payload_burst,
   input  logic [7:0]        axi_ar_payload_len,
   input  logic [3:0]        axi_ar_payload_size,
   input  logic [1:0]        axi_ar_payload_lock,
   input  logic [2:0]        axi_ar_payload_prot,
   input  logic [3:0]        axi_ar_payload_cache,
   input  logic [3:0]        axi_ar_payload_qos,
   input  logic [ID_W-1:0]   axi_ar_payload_id,
   output logic              axi_b_valid,
   input  logic              axi_b_ready,
   output logic              axi_b_first,
   output logic              axi_b_last,
   output logic [1:0]        axi_b_payload_resp,
   output logic [ID_W-1:0]   axi_b_payload_id,
   output logic              native_cmd_valid,
   input  logic              native_cmd_ready,
   output logic              native_cmd_first,
   output logic              native_cmd_last,
   output logic              native_cmd_payload_we,
   output logic [ADDR_W-1:0] native_cmd_payload_addr
);

   typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST, WR_RESP} state_t;

   state_t            state;
   logic              prio_rd;      // 0: AW wins a tie, 1: AR wins a tie
   logic [ADDR_W-1:0] start_addr;
   logic [1:0]        burst_q;
   logic [7:0]        len_q;
   logic [ID_W-1:0]   id_q;
   logic [8:0]        beat;         // 9 bits so len=255 (256 beats) fits
   logic [8:0]        beat_nxt;

   logic              idle;
   logic              aw_hs;
   logic              ar_hs;
   logic [ADDR_W-1:0] sel_addr;
   logic [1:0]        sel_burst;
   logic [7:0]        sel_len;
   logic [ID_W-1:0]   sel_id;

   // Fields the address channels carry but this block has no use for.
   logic unused_inputs;
   assign unused_inputs = ^{axi_aw_first, axi_aw_last, axi_aw_payload_size,
                            axi_aw_payload_lock, axi_aw_payload_prot,
                            axi_aw_payload_cache, axi_aw_payload_qos,
                            axi_ar_first, axi_ar_last, axi_ar_payload_size,
                            axi_ar_payload_lock, axi_ar_payload_prot,
                            axi_ar_payload_cache, axi_ar_payload_qos};

   // Readys are gated by reset so every output reads 0 while reset is held.
   assign idle         = (state == IDLE) && sys_rst;
   assign axi_aw_ready = idle && (!prio_rd || !axi_ar_valid);
   assign axi_ar_ready = idle && ( prio_rd || !axi_aw_valid);
   assign aw_hs        = axi_aw_valid && axi_aw_ready;
   assign ar_hs        = axi_ar_valid && axi_ar_ready;

   assign sel_addr  = aw_hs ? axi_aw_payload_addr  : axi_ar_payload_addr;
   assign sel_burst = aw_hs ? axi_aw_payload_burst : axi_ar_payload_burst;
   assign sel_len   = aw_hs ? axi_aw_payload_len   : axi_ar_payload_len;
   assign sel_id    = aw_hs ? axi_aw_payload_id    : axi_ar_payload_id;
   assign beat_nxt  = beat + 9'd1;

   assign axi_b_first        = axi_b_valid;
   assign axi_b_last         = axi_b_valid;
   assign axi_b_payload_resp = 2'b00;

   // Native beat address for a given beat of a burst. WRAP only wraps for the
   // legal AXI wrap lengths; any other length falls back to INCR behaviour.
   function automatic logic [ADDR_W-1:0] beat_addr(
      input logic [ADDR_W-1:0] start,
      input logic [1:0]        burst,
      input logic [7:0]        len,
      input logic [8:0]        nbeat
   );
      logic [ADDR_W-1:0] offset;
      logic [ADDR_W-1:0] mask;
      logic [ADDR_W-1:0] byte_addr;
      logic              wrap_ok;
      offset  = ADDR_W'(nbeat) << BEAT_SHIFT;
      mask    = ((ADDR_W'(len) + ADDR_W'(1)) << BEAT_SHIFT) - ADDR_W'(1);
      wrap_ok = (burst == 2'd2) &&
                (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
      if (burst == 2'd0)
         byte_addr = start;
      else if (wrap_ok)
         byte_addr = (start & ~mask) | ((start + offset) & mask);
      else
         byte_addr = start + offset;
      return byte_addr >> BEAT_SHIFT;
   endfunction

   always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
         state                   <= IDLE;
         prio_rd                 <= 1'b0;
         beat                    <= '0;
         native_cmd_valid        <= 1'b0;
         native_cmd_first        <= 1'b0;
         native_cmd_last         <= 1'b0;
         native_cmd_payload_we   <= 1'b0;
         native_cmd_payload_addr <= '0;
         axi_b_valid             <= 1'b0;
         axi_b_payload_id        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (aw_hs || ar_hs) begin
                  start_addr              <= sel_addr;
                  burst_q                 <= sel_burst;
                  len_q                   <= sel_len;
                  id_q                    <= sel_id;
                  beat                    <= '0;
                  prio_rd                 <= ~prio_rd;
                  native_cmd_valid        <= 1'b1;
                  native_cmd_first        <= 1'b1;
                  native_cmd_last         <= (sel_len == 8'd0);
                  native_cmd_payload_we   <= aw_hs;
                  native_cmd_payload_addr <= beat_addr(sel_addr, sel_burst, sel_len, 9'd0);
                  state                   <= aw_hs ? WR_BURST : RD_BURST;
               end
            end
            WR_BURST, RD_BURST: begin
               if (native_cmd_ready) begin
                  if (native_cmd_last) begin
                     native_cmd_valid <= 1'b0;
                     native_cmd_first <= 1'b0;
                     native_cmd_last  <= 1'b0;
                     if (state == WR_BURST) begin
                        axi_b_valid      <= 1'b1;
                        axi_b_payload_id <= id_q;
                        state            <= WR_RESP;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     beat                    <= beat_nxt;
                     native_cmd_first        <= 1'b0;
                     native_cmd_last         <= (beat_nxt == {1'b0, len_q});
                     native_cmd_payload_addr <= beat_addr(start_addr, burst_q, len_q, beat_nxt);
                  end
               end
            end
            WR_RESP: begin
               if (axi_b_ready) begin
                  axi_b_valid <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_cmd_frontend.sv
// ---------------------------------------------------------------------------
// tb_axi_cmd_frontend
// Scoreboard bench for axi_cmd_frontend. Address-channel drivers push the
// expected native beats and B responses when a handshake is seen; monitors
// pop and compare whenever the DUT completes a native command or B transfer.
// ---------------------------------------------------------------------------
module tb_axi_cmd_frontend;
   localparam int ADDR_W = 32;
   localparam int ID_W   = 1;

   logic              sys_clk = 1'b0;
   logic              sys_rst = 1'b0;
   logic              axi_aw_valid = 1'b0, axi_aw_ready;
   logic              axi_aw_first = 1'b0, axi_aw_last = 1'b0;
   logic [ADDR_W-1:0] axi_aw_payload_addr = '0;
   logic [1:0]        axi_aw_payload_burst = '0, axi_aw_payload_lock = '0;
   logic [7:0]        axi_aw_payload_len = '0;
   logic [3:0]        axi_aw_payload_size = '0, axi_aw_payload_cache = '0, axi_aw_payload_qos = '0;
   logic [2:0]        axi_aw_payload_prot = '0;
   logic [ID_W-1:0]   axi_aw_payload_id = '0;
   logic              axi_ar_valid = 1'b0, axi_ar_ready;
   logic              axi_ar_first = 1'b0, axi_ar_last = 1'b0;
   logic [ADDR_W-1:0] axi_ar_payload_addr = '0;
   logic [1:0]        axi_ar_payload_burst = '0, axi_ar_payload_lock = '0;
   logic [7:0]        axi_ar_payload_len = '0;
   logic [3:0]        axi_ar_payload_size = '0, axi_ar_payload_cache = '0, axi_ar_payload_qos = '0;
   logic [2:0]        axi_ar_payload_prot = '0;
   logic [ID_W-1:0]   axi_ar_payload_id = '0;
   logic              axi_b_valid, axi_b_first, axi_b_last;
   logic              axi_b_ready = 1'b0;
   logic [1:0]        axi_b_payload_resp;
   logic [ID_W-1:0]   axi_b_payload_id;
   logic              native_cmd_valid, native_cmd_first, native_cmd_last, native_cmd_payload_we;
   logic              native_cmd_ready = 1'b0;
   logic [ADDR_W-1:0] native_cmd_payload_addr;

   always #5 sys_clk = ~sys_clk;

   axi_cmd_frontend #(.ADDR_W(ADDR_W), .ID_W(ID_W), .BEAT_SHIFT(5)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready),
      .axi_aw_first(axi_aw_first), .axi_aw_last(axi_aw_last),
      .axi_aw_payload_addr(axi_aw_payload_addr), .axi_aw_payload_burst(axi_aw_payload_burst),
      .axi_aw_payload_len(axi_aw_payload_len), .axi_aw_payload_size(axi_aw_payload_size),
      .axi_aw_payload_lock(axi_aw_payload_lock), .axi_aw_payload_prot(axi_aw_payload_prot),
      .axi_aw_payload_cache(axi_aw_payload_cache), .axi_aw_payload_qos(axi_aw_payload_qos),
      .axi_aw_payload_id(axi_aw_payload_id),
      .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready),
      .axi_ar_first(axi_ar_first), .axi_ar_last(axi_ar_last),
      .axi_ar_payload_addr(axi_ar_payload_addr), .axi_ar_payload_burst(axi_ar_payload_burst),
      .axi_ar_payload_len(axi_ar_payload_len), .axi_ar_payload_size(axi_ar_payload_size),
      .axi_ar_payload_lock(axi_ar_payload_lock), .axi_ar_payload_prot(axi_ar_payload_prot),
      .axi_ar_payload_cache(axi_ar_payload_cache), .axi_ar_payload_qos(axi_ar_payload_qos),
      .axi_ar_payload_id(axi_ar_payload_id),
      .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready),
      .axi_b_first(axi_b_first), .axi_b_last(axi_b_last),
      .axi_b_payload_resp(axi_b_payload_resp), .axi_b_payload_id(axi_b_payload_id),
      .native_cmd_valid(native_cmd_valid), .native_cmd_ready(native_cmd_ready),
      .native_cmd_first(native_cmd_first), .native_cmd_last(native_cmd_last),
      .native_cmd_payload_we(native_cmd_payload_we),
      .native_cmd_payload_addr(native_cmd_payload_addr)
   );

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic        first;
      logic        last;
   } cmd_t;

   cmd_t exp_cmd[$];
   logic exp_b[$];
   int   n_pass  = 0;
   int   n_total = 0;
   bit   rnd_cmd = 1'b1, rnd_b = 1'b1;
   logic cmd_force = 1'b0, b_force = 1'b0;
   logic mprio_rd = 1'b0;    // model: which channel wins a tie (1 = read)
   logic [31:0] p_addr[2];
   logic [1:0]  p_burst[2];
   logic [7:0]  p_len[2];
   logic        p_id[2];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
   endtask

   task automatic fail_now(input string name);
      n_total++;
      $display("FAIL %s: got no/extra DUT event, expected one matching the model at t=%0t", name, $time);
   endtask

   // Reference address: byte-domain arithmetic, then divide by the 32-byte beat.
   function automatic logic [31:0] model_addr(input logic [31:0] start, input logic [1:0] burst,
                                              input logic [7:0] len, input int i);
      longint s, win, b;
      s   = longint'(start);
      win = (longint'(len) + 1) * 32;
      if (burst == 2'd0)
         b = s;
      else if (burst == 2'd2 && (len == 1 || len == 3 || len == 7 || len == 15))
         b = (s - s % win) + ((s % win + longint'(i) * 32) % win);
      else
         b = (s + longint'(i) * 32) % 64'sh1_0000_0000;
      return 32'(b / 32);
   endfunction

   task automatic push_burst(input bit rd);
      for (int i = 0; i <= int'(p_len[rd]); i++) begin
         cmd_t c;
         c.we    = !rd;
         c.addr  = model_addr(p_addr[rd], p_burst[rd], p_len[rd], i);
         c.first = (i == 0);
         c.last  = (i == int'(p_len[rd]));
         exp_cmd.push_back(c);
      end
      if (!rd) exp_b.push_back(p_id[rd]);
      mprio_rd = ~mprio_rd;
   endtask

   task automatic drive_set(input bit rd, input logic [31:0] a, input logic [1:0] b,
                            input logic [7:0] l, input logic id);
      p_addr[rd] = a; p_burst[rd] = b; p_len[rd] = l; p_id[rd] = id;
      if (!rd) begin
         axi_aw_payload_addr = a; axi_aw_payload_burst = b; axi_aw_payload_len = l;
         axi_aw_payload_id = id; axi_aw_payload_size = 4'($urandom);
         axi_aw_payload_qos = 4'($urandom); axi_aw_first = 1'($urandom);
         axi_aw_valid = 1'b1;
      end else begin
         axi_ar_payload_addr = a; axi_ar_payload_burst = b; axi_ar_payload_len = l;
         axi_ar_payload_id = id; axi_ar_payload_size = 4'($urandom);
         axi_ar_payload_qos = 4'($urandom); axi_ar_first = 1'($urandom);
         axi_ar_valid = 1'b1;
      end
   endtask

   task automatic drop(input bit rd);
      if (!rd) axi_aw_valid = 1'b0;
      else     axi_ar_valid = 1'b0;
   endtask

   task automatic wait_hs(input bit rd);
      int n = 0;
      bit ok = 1'b0;
      while (n < 3000) begin
         @(negedge sys_clk);
         if (rd ? (axi_ar_valid && axi_ar_ready) : (axi_aw_valid && axi_aw_ready)) begin
            ok = 1'b1;
            break;
         end
         n++;
      end
      if (ok) push_burst(rd);
      else fail_now(rd ? "ar_handshake_timeout" : "aw_handshake_timeout");
      @(posedge sys_clk); #1;
      drop(rd);
   endtask

   task automatic send(input bit rd, input logic [31:0] a, input logic [1:0] b,
                       input logic [7:0] l, input logic id);
      @(posedge sys_clk); #1;
      drive_set(rd, a, b, l, id);
      wait_hs(rd);
   endtask

   // Both channels valid together: the grant must follow the model's priority.
   task automatic send_pair(input logic [31:0] wa, input logic [1:0] wb, input logic [7:0] wl,
                            input logic wi, input logic [31:0] ra, input logic [1:0] rb,
                            input logic [7:0] rl, input logic ri);
      int n = 0;
      bit ok = 1'b0;
      bit g;
      @(posedge sys_clk); #1;
      drive_set(1'b0, wa, wb, wl, wi);
      drive_set(1'b1, ra, rb, rl, ri);
      while (n < 3000) begin
         @(negedge sys_clk);
         if ((axi_aw_valid && axi_aw_ready) || (axi_ar_valid && axi_ar_ready)) begin
            ok = 1'b1;
            break;
         end
         n++;
      end
      if (!ok) begin
         fail_now("pair_grant_timeout");
         drop(1'b0); drop(1'b1);
      end else begin
         g = axi_ar_valid && axi_ar_ready;
         chk("grant_order", 64'(g), 64'(mprio_rd));
         chk("single_grant", 64'(axi_aw_ready && axi_ar_ready), 64'd0);
         push_burst(g);
         @(posedge sys_clk); #1;
         drop(g);
         wait_hs(!g);
      end
   endtask

   function automatic logic [63:0] all_outputs();
      return 64'({axi_aw_ready, axi_ar_ready, axi_b_valid, axi_b_first, axi_b_last,
                  axi_b_payload_resp, axi_b_payload_id, native_cmd_valid, native_cmd_first,
                  native_cmd_last, native_cmd_payload_we, native_cmd_payload_addr});
   endfunction

   // Ready generators: random backpressure, or a level forced by directed tests.
   initial begin
      forever begin
         @(posedge sys_clk); #1;
         native_cmd_ready = rnd_cmd ? ($urandom_range(0, 3) != 0) : cmd_force;
         axi_b_ready      = rnd_b   ? ($urandom_range(0, 1) == 1) : b_force;
      end
   end

   // Monitor: native command stream and B channel.
   initial begin
      cmd_t        c;
      logic [35:0] held;
      bit          stall;
      logic        eb;
      stall = 1'b0;
      held  = '0;
      forever begin
         @(negedge sys_clk);
         if (!sys_rst) begin
            stall = 1'b0;
         end else begin
            if (stall)
               chk("cmd_hold", 64'({native_cmd_valid, native_cmd_payload_we, native_cmd_payload_addr,
                                    native_cmd_first, native_cmd_last}), 64'(held));
            if (native_cmd_valid && native_cmd_ready) begin
               if (exp_cmd.size() == 0) fail_now("unexpected_cmd");
               else begin
                  c = exp_cmd.pop_front();
                  chk("cmd_we",    64'(native_cmd_payload_we),   64'(c.we));
                  chk("cmd_addr",  64'(native_cmd_payload_addr), 64'(c.addr));
                  chk("cmd_first", 64'(native_cmd_first),        64'(c.first));
                  chk("cmd_last",  64'(native_cmd_last),         64'(c.last));
               end
            end
            stall = native_cmd_valid && !native_cmd_ready;
            held  = {native_cmd_valid, native_cmd_payload_we, native_cmd_payload_addr,
                     native_cmd_first, native_cmd_last};
            if (axi_b_valid && axi_b_ready) begin
               if (exp_b.size() == 0) fail_now("unexpected_b");
               else begin
                  eb = exp_b.pop_front();
                  chk("b_id",   64'(axi_b_payload_id),   64'(eb));
                  chk("b_resp", 64'(axi_b_payload_resp), 64'd0);
                  chk("b_first_last", 64'({axi_b_first, axi_b_last}), 64'b11);
               end
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // Reset held 3 clocks with both address channels requesting.
      sys_rst = 1'b0;
      axi_aw_valid = 1'b1;
      axi_ar_valid = 1'b1;
      repeat (3) begin
         @(negedge sys_clk);
         chk("reset_outputs", all_outputs(), 64'd0);
      end
      axi_aw_valid = 1'b0;
      axi_ar_valid = 1'b0;
      @(posedge sys_clk); #1;
      sys_rst = 1'b1;

      // Simultaneous requests right after reset: W, R, W, R.
      send_pair(32'h0000_0100, 2'd1, 8'd1, 1'b1, 32'h0000_0200, 2'd1, 8'd2, 1'b0);
      send_pair(32'h0000_0400, 2'd1, 8'd0, 1'b0, 32'h0000_0800, 2'd0, 8'd1, 1'b1);

      // Single-beat write with native ready tied high.
      rnd_cmd = 1'b0; cmd_force = 1'b1;
      send(1'b0, 32'h0000_1000, 2'd1, 8'd0, 1'b1);

      // INCR read with beat 1 stalled for two cycles.
      cmd_force = 1'b0;
      repeat (3) @(posedge sys_clk);
      send(1'b1, 32'h0000_2000, 2'd1, 8'd3, 1'b0);
      n = 0;
      do begin
         @(negedge sys_clk);
         n++;
      end while (!native_cmd_valid && n < 50);
      if (!native_cmd_valid) fail_now("read_cmd_timeout");
      cmd_force = 1'b1;
      @(negedge sys_clk);
      cmd_force = 1'b0;
      repeat (2) @(negedge sys_clk);
      cmd_force = 1'b1;
      repeat (6) @(negedge sys_clk);
      rnd_cmd = 1'b1;

      // WRAP read.
      send(1'b1, 32'h0000_0060, 2'd2, 8'd3, 1'b0);

      // FIXED write with B held off while an AR waits.
      rnd_b = 1'b0; b_force = 1'b0;
      send(1'b0, 32'h0000_0040, 2'd0, 8'd2, 1'b0);
      @(posedge sys_clk); #1;
      drive_set(1'b1, 32'h0000_3000, 2'd1, 8'd1, 1'b1);
      n = 0;
      while (!axi_b_valid && n < 300) begin
         @(negedge sys_clk);
         n++;
      end
      if (!axi_b_valid) fail_now("b_valid_timeout");
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge sys_clk);
         chk("b_hold_valid", 64'(axi_b_valid), 64'd1);
         chk("ar_blocked",   64'(axi_ar_ready), 64'd0);
      end
      b_force = 1'b1;
      wait_hs(1'b1);
      rnd_b = 1'b1;

      // Longest burst, crossing the top of the address space.
      send(1'b0, 32'hFFFF_F000, 2'd1, 8'd255, 1'b1);

      // Reset in the middle of a write burst: no B may follow.
      send(1'b0, 32'h0001_0000, 2'd1, 8'd15, 1'b1);
      repeat (6) @(posedge sys_clk);
      #1;
      sys_rst = 1'b0;
      exp_cmd.delete();
      exp_b.delete();
      mprio_rd = 1'b0;
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      chk("midburst_reset_outputs", all_outputs(), 64'd0);
      @(posedge sys_clk); #1;
      sys_rst = 1'b1;
      repeat (20) begin
         @(negedge sys_clk);
         chk("no_stale_traffic", 64'({axi_b_valid, native_cmd_valid}), 64'd0);
      end

      // Randomized mix of writes, reads and simultaneous pairs.
      for (int t = 0; t < 40; t++) begin
         logic [31:0] a0, a1;
         logic [1:0]  b0, b1;
         logic [7:0]  l0, l1;
         int          kind;
         kind = $urandom_range(0, 2);
         a0 = $urandom; a1 = $urandom;
         b0 = 2'($urandom); b1 = 2'($urandom);
         case ($urandom_range(0, 5))
            0: l0 = 8'd0;  1: l0 = 8'd1;  2: l0 = 8'd3;
            3: l0 = 8'd7;  4: l0 = 8'd15; default: l0 = 8'($urandom_range(0, 20));
         endcase
         case ($urandom_range(0, 5))
            0: l1 = 8'd0;  1: l1 = 8'd1;  2: l1 = 8'd3;
            3: l1 = 8'd7;  4: l1 = 8'd15; default: l1 = 8'($urandom_range(0, 20));
         endcase
         if (kind == 0)      send(1'b0, a0, b0, l0, 1'($urandom));
         else if (kind == 1) send(1'b1, a1, b1, l1, 1'($urandom));
         else send_pair(a0, b0, l0, 1'($urandom), a1, b1, l1, 1'($urandom));
      end

      n = 0;
      while ((exp_cmd.size() != 0 || exp_b.size() != 0) && n < 5000) begin
         @(negedge sys_clk);
         n++;
      end
      if (exp_cmd.size() != 0 || exp_b.size() != 0) fail_now("drain_timeout");
      repeat (5) @(negedge sys_clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
